// File: rtl/if_id_skid_reg_pkg.sv
// Shared IF/ID definitions: default widths, bubble encoding, entry and state types.
package if_id_pkg;
  localparam int              PC_W      = 30;
  localparam int              INSTR_W   = 32;
  localparam int              CNT_W     = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    npc;
    logic [INSTR_W-1:0] instr;
  } if_id_entry_t;

  // main_valid is bit 0, skid_valid is bit 1
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } if_id_state_e;
endpackage

// File: rtl/if_id_skid_reg_if.sv
// Fetch-to-decode handshake bundle; slave is the register, master drives it.
interface if_id_skid_reg_if #(
  parameter int PC_W    = if_id_pkg::PC_W,
  parameter int INSTR_W = if_id_pkg::INSTR_W
);
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_npc;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_npc;
  logic [INSTR_W-1:0] out_instr;

  modport slave (
    input  in_valid, in_npc, in_instr, out_ready,
    output in_ready, out_valid, out_npc, out_instr
  );

  modport master (
    output in_valid, in_npc, in_instr, out_ready,
    input  in_ready, out_valid, out_npc, out_instr
  );
endinterface

// File: rtl/if_id_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);
  // count up until all-ones, clear wins over inc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     count <= '0;
    else if (clear)                 count <= '0;
    else if (inc && (count != '1))  count <= count + 1'b1;
  end
endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register: main + skid entry, registered in_ready,
// flush-to-bubble, cache-miss freeze and a saturating stall counter.
module if_id_skid_reg #(
  parameter int                  PC_W      = if_id_pkg::PC_W,
  parameter int                  INSTR_W   = if_id_pkg::INSTR_W,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = if_id_pkg::NOP_INSTR,
  parameter int                  CNT_W     = if_id_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instruction_hit,
  input  logic               data_hit,
  input  logic               flush,
  if_id_skid_reg_if.slave    bus,
  output logic [CNT_W-1:0]   stall_cycles
);
  import if_id_pkg::*;

  // sized by this instance's parameters rather than the package defaults
  typedef struct packed {
    logic [PC_W-1:0]    npc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  if_id_state_e state_q, state_d;
  entry_t       main_q, skid_q, in_entry;
  logic         in_ready_q;
  logic         main_valid, hit_ok, push, pop;

  assign main_valid = (state_q != EMPTY);
  assign hit_ok     = instruction_hit & data_hit;
  assign push       = bus.in_valid & in_ready_q & hit_ok;
  assign pop        = main_valid & bus.out_ready & hit_ok;
  assign in_entry   = '{npc: bus.in_npc, instr: bus.in_instr};

  // next occupancy; flush empties even during a miss
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (hit_ok) begin
      case (state_q)
        EMPTY:   if (push) state_d = ONE;
        ONE:     if (pop && !push) state_d = EMPTY;
                 else if (push && !pop) state_d = TWO;
        TWO:     if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // occupancy and in_ready both come straight from flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  // entry datapath: skid only fills when main is held, and drains into main
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '{npc: '0, instr: NOP_INSTR};
      skid_q <= '0;
    end else if (!flush && hit_ok) begin
      case (state_q)
        EMPTY: if (push) main_q <= in_entry;
        ONE:   if (push) begin
                 if (pop) main_q <= in_entry;
                 else     skid_q <= in_entry;
               end
        TWO:   if (pop) main_q <= skid_q;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid;
  assign bus.out_npc   = main_q.npc;
  assign bus.out_instr = main_valid ? main_q.instr : NOP_INSTR;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (main_valid & ~pop),
    .clear (1'b0),
    .count (stall_cycles)
  );
endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg: reset, streaming, back-pressure,
// miss freeze, flush and counter saturation (second instance, CNT_W=4).
module tb_if_id_skid_reg;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        instruction_hit, data_hit, flush;
  logic [15:0] stall16;
  logic [3:0]  stall4;
  int          vectors = 0;
  int          errors  = 0;

  if_id_skid_reg_if #(.PC_W(30), .INSTR_W(32)) bus ();
  if_id_skid_reg_if #(.PC_W(30), .INSTR_W(32)) bus4 ();

  if_id_skid_reg #(.PC_W(30), .INSTR_W(32), .NOP_INSTR(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instruction_hit(instruction_hit), .data_hit(data_hit),
    .flush(flush), .bus(bus), .stall_cycles(stall16)
  );

  if_id_skid_reg #(.PC_W(30), .INSTR_W(32), .NOP_INSTR(32'h0), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .instruction_hit(instruction_hit), .data_hit(data_hit),
    .flush(flush), .bus(bus4), .stall_cycles(stall4)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs;
    instruction_hit = 1'b1; data_hit = 1'b1; flush = 1'b0;
    bus.in_valid  = 1'b0; bus.in_npc  = '0; bus.in_instr  = '0; bus.out_ready  = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_npc = '0; bus4.in_instr = '0; bus4.out_ready = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_val(input logic [29:0] npc, input logic [31:0] instr);
    bus.in_valid = 1'b1; bus.in_npc = npc; bus.in_instr = instr;
  endtask

  task automatic test_reset;
    do_reset();
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.out_npc, bus.out_instr, stall16} !== {1'b0, 1'b1, 30'h0, 32'h0, 16'h0}) begin
      errors++; $display("FAIL reset_init got v=%b r=%b npc=%h instr=%h stall=%0d", bus.out_valid, bus.in_ready, bus.out_npc, bus.out_instr, stall16);
    end
    // fill to TWO, then reset mid-cycle
    push_val(30'h70, 32'hF0); tick();
    push_val(30'h71, 32'hF1); tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_npc !== 30'h70) begin
      errors++; $display("FAIL reset_prefill got r=%b npc=%h want r=0 npc=70", bus.in_ready, bus.out_npc);
    end
    #2; rst_n = 1'b0; #1;
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.out_npc, bus.out_instr, stall16} !== {1'b0, 1'b1, 30'h0, 32'h0, 16'h0}) begin
      errors++; $display("FAIL reset_async got v=%b r=%b npc=%h instr=%h stall=%0d", bus.out_valid, bus.in_ready, bus.out_npc, bus.out_instr, stall16);
    end
    tick(); rst_n = 1'b1;
    bus.out_ready = 1'b1; tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_dataloss got v=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_streaming;
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_val(30'(32'h10 + i), 32'hA0 + 32'(i));
      tick();
      vectors++;
      if ({bus.out_valid, bus.in_ready, bus.out_npc, bus.out_instr} !== {1'b1, 1'b1, 30'(32'h10 + i), 32'hA0 + 32'(i)}) begin
        errors++; $display("FAIL stream_%0d got v=%b r=%b npc=%h instr=%h want npc=%h", i, bus.out_valid, bus.in_ready, bus.out_npc, bus.out_instr, 32'h10 + i);
      end
    end
    bus.in_valid = 1'b0; tick();
    vectors++;
    if ({bus.out_valid, bus.out_instr, stall16} !== {1'b0, 32'h0, 16'h0}) begin
      errors++; $display("FAIL stream_drain got v=%b instr=%h stall=%0d want 0/0/0", bus.out_valid, bus.out_instr, stall16);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    push_val(30'h20, 32'hB0); tick();
    vectors++;
    if ({bus.in_ready, bus.out_valid, stall16} !== {1'b1, 1'b1, 16'd0}) begin
      errors++; $display("FAIL bp_first got r=%b v=%b stall=%0d want 1/1/0", bus.in_ready, bus.out_valid, stall16);
    end
    push_val(30'h21, 32'hB1); tick();
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.in_ready, bus.out_npc, stall16} !== {1'b0, 30'h20, 16'd1}) begin
      errors++; $display("FAIL bp_full got r=%b npc=%h stall=%0d want 0/20/1", bus.in_ready, bus.out_npc, stall16);
    end
    for (int k = 2; k <= 4; k++) begin
      tick();
      vectors++;
      if ({bus.in_ready, bus.out_npc, stall16} !== {1'b0, 30'h20, 16'(k)}) begin
        errors++; $display("FAIL bp_hold_%0d got r=%b npc=%h stall=%0d want 0/20/%0d", k, bus.in_ready, bus.out_npc, stall16, k);
      end
    end
    bus.out_ready = 1'b1; tick();
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.out_npc, bus.out_instr, stall16} !== {1'b1, 1'b1, 30'h21, 32'hB1, 16'd4}) begin
      errors++; $display("FAIL bp_release1 got v=%b r=%b npc=%h instr=%h stall=%0d want 1/1/21/b1/4", bus.out_valid, bus.in_ready, bus.out_npc, bus.out_instr, stall16);
    end
    tick();
    vectors++;
    if ({bus.out_valid, bus.out_instr} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL bp_release2 got v=%b instr=%h want 0/0", bus.out_valid, bus.out_instr);
    end
  endtask

  task automatic test_miss_freeze;
    do_reset();
    push_val(30'h40, 32'hC0); tick();
    push_val(30'h41, 32'hC1);
    bus.out_ready = 1'b1; data_hit = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      vectors++;
      if ({bus.out_valid, bus.in_ready, bus.out_npc, bus.out_instr, stall16} !== {1'b1, 1'b1, 30'h40, 32'hC0, 16'(k)}) begin
        errors++; $display("FAIL miss_%0d got v=%b r=%b npc=%h instr=%h stall=%0d want 1/1/40/c0/%0d", k, bus.out_valid, bus.in_ready, bus.out_npc, bus.out_instr, stall16, k);
      end
    end
    data_hit = 1'b1; tick();
    vectors++;
    if ({bus.out_valid, bus.out_npc, bus.out_instr, stall16} !== {1'b1, 30'h41, 32'hC1, 16'd5}) begin
      errors++; $display("FAIL miss_resume got v=%b npc=%h instr=%h stall=%0d want 1/41/c1/5", bus.out_valid, bus.out_npc, bus.out_instr, stall16);
    end
  endtask

  task automatic test_flush;
    do_reset();
    push_val(30'h50, 32'hD0); tick();
    push_val(30'h51, 32'hD1); tick();
    flush = 1'b1; push_val(30'h30, 32'hE0); tick();
    flush = 1'b0; bus.in_valid = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.out_npc, bus.out_instr, stall16} !== {1'b0, 1'b1, 30'h50, 32'h0, 16'd2}) begin
      errors++; $display("FAIL flush_two got v=%b r=%b npc=%h instr=%h stall=%0d want 0/1/50/0/2", bus.out_valid, bus.in_ready, bus.out_npc, bus.out_instr, stall16);
    end
    bus.out_ready = 1'b1; tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_npc === 30'h30) begin
      errors++; $display("FAIL flush_noleak got v=%b npc=%h want v=0", bus.out_valid, bus.out_npc);
    end
    // flush from ONE while a push would otherwise land
    push_val(30'h60, 32'hD6); tick();
    flush = 1'b1; push_val(30'h30, 32'hE0); tick();
    flush = 1'b0; bus.in_valid = 1'b0; tick();
    vectors++;
    if ({bus.out_valid, bus.in_ready, bus.out_instr} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL flush_one got v=%b r=%b instr=%h want 0/1/0", bus.out_valid, bus.in_ready, bus.out_instr);
    end
  endtask

  task automatic test_saturation;
    do_reset();
    bus4.in_valid = 1'b1; bus4.in_npc = 30'h1; bus4.in_instr = 32'h1; tick();
    bus4.in_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      vectors++;
      if (stall4 !== ((k > 15) ? 4'hF : 4'(k))) begin
        errors++; $display("FAIL sat_%0d got %0d want %0d", k, stall4, (k > 15) ? 15 : k);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_miss_freeze();
    test_flush();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
